// File: rtl/cmac_pkg.sv
// Shared constants and helpers for the complex accumulator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cmac_pkg;

   localparam int CMAC_IN_W = 64;
   localparam int CMAC_LEN  = 16;

   // Smallest accumulator width that cannot wrap when summing len products.
   function automatic int cmac_acc_w(input int in_w, input int len);
      return in_w + $clog2(len);
   endfunction

   // Default width: the minimum width rounded up to a whole byte.
   localparam int CMAC_ACC_W = ((cmac_acc_w(CMAC_IN_W, CMAC_LEN) + 7) / 8) * 8;

endpackage

// File: rtl/cmac_lane.sv
// One real-valued frame accumulator (used once for re, once for im).
// Latency: sum is combinational (acc + x); acc updates on the clock edge.
// Backpressure: none; every product presented with add is absorbed.
// Ports: clk, rst_n; add = product valid; clr = restart frame; done = this
//        product completes the frame; x = signed product; sum = acc + x.
module cmac_lane
   import cmac_pkg::*;
#(
   parameter int IN_W  = CMAC_IN_W,
   parameter int ACC_W = CMAC_ACC_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             add,
   input  logic             clr,
   input  logic             done,
   input  logic [IN_W-1:0]  x,
   output logic [ACC_W-1:0] sum
);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] xs;

   assign xs  = ACC_W'($signed(x));
   assign sum = acc + xs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         // A product arriving with clr is the first of the new frame.
         acc <= add ? xs : '0;
      end else if (add) begin
         acc <= done ? '0 : sum;
      end
   end

endmodule

// File: rtl/cmac_accum.sv
// Streaming complex accumulator: sums LEN valid products into one result.
// Latency: result visible the cycle after the completing product's edge.
// Backpressure: never stalls input; one result register, overflow sets sticky ovr.
// Ports: in_valid/in_re/in_im = product stream; clr = abandon frame, clear ovr;
//        out_valid/out_ready/out_re/out_im = result handshake; ovr = dropped
//        result flag; cnt = products accumulated in the current frame.
module cmac_accum
   import cmac_pkg::*;
#(
   parameter int IN_W  = CMAC_IN_W,
   parameter int LEN   = CMAC_LEN,
   parameter int ACC_W = ((cmac_acc_w(IN_W, LEN) + 7) / 8) * 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [IN_W-1:0]        in_re,
   input  logic [IN_W-1:0]        in_im,
   input  logic                   clr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_re,
   output logic [ACC_W-1:0]       out_im,
   output logic                   ovr,
   output logic [$clog2(LEN)-1:0] cnt
);

   localparam int CW = $clog2(LEN);

   if (LEN < 2) begin : g_bad_len
      $error("cmac_accum: LEN must be at least 2");
   end
   if (ACC_W < cmac_acc_w(IN_W, LEN)) begin : g_bad_acc_w
      $error("cmac_accum: ACC_W too narrow for IN_W and LEN");
   end

   logic             last;
   logic             done;
   logic             reg_free;
   logic [ACC_W-1:0] sum_re;
   logic [ACC_W-1:0] sum_im;

   assign last     = (cnt == CW'(LEN - 1));
   // clr restarts the frame, so it can never complete one in the same cycle.
   assign done     = in_valid && !clr && last;
   // The result register can take a new sum if empty or being drained now.
   assign reg_free = !out_valid || out_ready;

   cmac_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_re (
      .clk   (clk),
      .rst_n (rst_n),
      .add   (in_valid),
      .clr   (clr),
      .done  (done),
      .x     (in_re),
      .sum   (sum_re)
   );

   cmac_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane_im (
      .clk   (clk),
      .rst_n (rst_n),
      .add   (in_valid),
      .clr   (clr),
      .done  (done),
      .x     (in_im),
      .sum   (sum_im)
   );

   // Frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= in_valid ? CW'(1) : '0;
      end else if (in_valid) begin
         cnt <= done ? '0 : cnt + CW'(1);
      end
   end

   // Result register and output handshake; independent of clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else if (done && reg_free) begin
         out_valid <= 1'b1;
         out_re    <= sum_re;
         out_im    <= sum_im;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky drop flag: a completed sum found the register still occupied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr <= 1'b0;
      end else if (clr) begin
         ovr <= 1'b0;
      end else if (done && !reg_free) begin
         ovr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cmac_accum.sv
module tb_cmac_accum;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_re;
   logic [63:0] in_im;
   logic        clr;
   logic        out_valid;
   logic        out_ready;
   logic [65:0] out_re;
   logic [65:0] out_im;
   logic        ovr;
   logic [1:0]  cnt;

   int checks = 0;
   int passed = 0;

   cmac_accum #(.IN_W(64), .LEN(4), .ACC_W(66)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_re     (in_re),
      .in_im     (in_im),
      .clr       (clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .ovr       (ovr),
      .cnt       (cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   // Present one input beat, then sample 1 time unit after the edge.
   task automatic cyc(input logic v, input longint re, input longint im);
      in_valid = v;
      in_re    = re;
      in_im    = im;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      clr       = 1'b0;
      out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 66'(out_valid), 66'd0);
      chk("rst_out_re", out_re, 66'd0);
      chk("rst_out_im", out_im, 66'd0);
      chk("rst_ovr", 66'(ovr), 66'd0);
      chk("rst_cnt", 66'(cnt), 66'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic frame.
      cyc(1, 1, 2);  chk("basic_cnt1", 66'(cnt), 66'd1);
      cyc(1, 3, 4);  chk("basic_cnt2", 66'(cnt), 66'd2);
      cyc(1, 5, 6);  chk("basic_cnt3", 66'(cnt), 66'd3);
                     chk("basic_not_yet", 66'(out_valid), 66'd0);
      cyc(1, 7, 8);  chk("basic_cnt0", 66'(cnt), 66'd0);
                     chk("basic_valid", 66'(out_valid), 66'd1);
                     chk("basic_re", out_re, 66'd16);
                     chk("basic_im", out_im, 66'd20);
      cyc(0, 0, 0);  chk("basic_drain", 66'(out_valid), 66'd0);
                     chk("basic_re_kept", out_re, 66'd16);

      // Width extremes.
      for (int i = 0; i < 4; i++) cyc(1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("ext_valid", 66'(out_valid), 66'd1);
      chk("ext_re", out_re, 66'h2_0000_0000_0000_0000);
      chk("ext_im", out_im, 66'h1_FFFF_FFFF_FFFF_FFFC);
      chk("ext_ovr", 66'(ovr), 66'd0);
      cyc(0, 0, 0);  chk("ext_drain", 66'(out_valid), 66'd0);

      // Back-pressure: stall up to LEN-1 cycles is lossless, beyond drops.
      for (int i = 0; i < 3; i++) cyc(1, 1, 1);
      out_ready = 1'b0;
      cyc(1, 1, 1);  chk("bp_valid", 66'(out_valid), 66'd1);
                     chk("bp_re", out_re, 66'd4);
      for (int i = 0; i < 3; i++) cyc(1, 2, 2);
      chk("bp_hold_valid", 66'(out_valid), 66'd1);
      chk("bp_hold_re", out_re, 66'd4);
      chk("bp_hold_ovr", 66'(ovr), 66'd0);
      cyc(1, 2, 2);  chk("bp_drop_ovr", 66'(ovr), 66'd1);
                     chk("bp_drop_re", out_re, 66'd4);
                     chk("bp_drop_im", out_im, 66'd4);
                     chk("bp_drop_valid", 66'(out_valid), 66'd1);
                     chk("bp_drop_cnt", 66'(cnt), 66'd0);

      // clr mid-frame; old result stays; completion coincides with a drain.
      cyc(1, 5, 5);
      cyc(1, 5, 5);
      clr = 1'b1;
      cyc(1, 10, 10);
      clr = 1'b0;
      chk("clr_cnt", 66'(cnt), 66'd1);
      chk("clr_ovr", 66'(ovr), 66'd0);
      chk("clr_keeps_valid", 66'(out_valid), 66'd1);
      chk("clr_keeps_re", out_re, 66'd4);
      cyc(1, 1, 1);
      cyc(1, 1, 1);  chk("clr_cnt3", 66'(cnt), 66'd3);
      out_ready = 1'b1;
      cyc(1, 1, 1);  chk("clr_valid", 66'(out_valid), 66'd1);
                     chk("clr_re", out_re, 66'd13);
                     chk("clr_im", out_im, 66'd13);
                     chk("clr_ovr_after", 66'(ovr), 66'd0);
      cyc(0, 0, 0);  chk("clr_drain", 66'(out_valid), 66'd0);

      // Gapped input: idle beats carry junk that must be ignored.
      cyc(1, 1, -1);
      cyc(0, 99, 99); chk("gap_cnt1", 66'(cnt), 66'd1);
      cyc(1, 2, -2);
      cyc(0, 99, 99); chk("gap_cnt2", 66'(cnt), 66'd2);
      cyc(1, 3, -3);
      cyc(0, 99, 99); chk("gap_cnt3", 66'(cnt), 66'd3);
                      chk("gap_not_yet", 66'(out_valid), 66'd0);
      cyc(1, 4, -4);  chk("gap_valid", 66'(out_valid), 66'd1);
                      chk("gap_re", out_re, 66'd10);
                      chk("gap_im", out_im, -66'sd10);
      cyc(0, 99, 99); chk("gap_drain", 66'(out_valid), 66'd0);
                      chk("gap_cnt0", 66'(cnt), 66'd0);

      // Asynchronous reset with a result pending and a partial frame.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1, 1, 1);
      cyc(1, 7, 7);
      cyc(1, 7, 7);
      chk("pre_rst_valid", 66'(out_valid), 66'd1);
      chk("pre_rst_cnt", 66'(cnt), 66'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 66'(out_valid), 66'd0);
      chk("arst_re", out_re, 66'd0);
      chk("arst_im", out_im, 66'd0);
      chk("arst_cnt", 66'(cnt), 66'd0);
      chk("arst_ovr", 66'(ovr), 66'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      cyc(1, 10, -3);
      cyc(1, 20, -3);
      cyc(1, 30, -3); chk("post_rst_cnt3", 66'(cnt), 66'd3);
      cyc(1, 40, -3); chk("post_rst_valid", 66'(out_valid), 66'd1);
                      chk("post_rst_re", out_re, 66'd100);
                      chk("post_rst_im", out_im, -66'sd12);
      in_valid = 1'b0;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/cmac_accum.md
# cmac_accum

Streaming complex accumulator that sits directly downstream of the 3-stage pipelined complex multiplier. It consumes the multiplier's 64-bit signed real and imaginary products, sums LEN consecutive valid products into a complex dot-product result, and presents each result on a valid/ready output port. The multiplier cannot stall, so this block never back-pressures its input. It absorbs output stalls with a single result register and flags any result it has to drop.

## Interface
Parameters:
- IN_W, 64: width of each signed input component (real and imaginary).
- LEN, 16: products per frame; must be ≥ 2.
- ACC_W, 72: accumulator and output width; elaboration error if ACC_W < IN_W + $clog2(LEN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_re/in_im hold a product this cycle; always accepted.
- in_re  in  IN_W  signed real product.
- in_im  in  IN_W  signed imaginary product.
- clr  in  1  synchronous clear: abandons the partial frame and clears ovr.
- out_valid  out  1  result held on out_re/out_im.
- out_ready  in  1  downstream accepts the result when out_valid && out_ready.
- out_re  out  ACC_W  signed frame sum, real part.
- out_im  out  ACC_W  signed frame sum, imaginary part.
- ovr  out  1  sticky flag: a completed frame was dropped.
- cnt  out  $clog2(LEN)  number of products accumulated in the current frame.

## Operation
- All arithmetic is signed. Inputs are sign-extended to ACC_W. With the ACC_W rule above, no wrap or saturation occurs.
- Frame counting:
  - A valid product with cnt < LEN-1 sets acc += x and cnt += 1.
  - A valid product with cnt == LEN-1 completes the frame: sum = acc + x, acc ← 0, cnt ← 0.
  - The next frame may start on the very next cycle; there are no bubbles between frames.
- Result register:
  - On frame completion, if the register is free (!out_valid, or out_valid && out_ready in the same cycle), load out_re/out_im with the sum and set out_valid = 1.
  - Otherwise keep the old result, discard the new sum, and set ovr ← 1.
- Output handshake: when out_valid && out_ready with no completion in the same cycle, out_valid ← 0. out_re/out_im keep their last value.
- clr:
  - Sets acc ← 0, cnt ← 0, ovr ← 0.
  - Does not touch out_valid, out_re or out_im.
  - If in_valid is high in the same cycle, that product becomes the first of a new frame (acc ← x, cnt ← 1). With clr, completion is impossible in that cycle.
- Reset (any time, including mid-frame or with a result pending): acc, cnt, out_re, out_im, out_valid and ovr all go to 0. The partial frame and the pending result are lost.

## Timing
- Latency: the completing product accepted at edge t produces out_valid = 1 with the result after edge t, i.e. visible in cycle t+1.
- Throughput: one product per cycle, sustained indefinitely. One result per LEN cycles.
- Stall tolerance: out_ready may stay low for up to LEN-1 cycles after out_valid rises without any loss. A longer stall risks ovr.
- cnt and ovr are registered and update on the same edge as the event that changes them.

## Structure
- Shared package cmac_pkg holds:
  - CMAC_IN_W = 64
  - default CMAC_LEN
  - a function cmac_acc_w(in_w, len) returning in_w + $clog2(len), used for the ACC_W default and for the elaboration check.
- Sub-module cmac_lane: one real-valued accumulator (sign-extend, add, clear-on-complete), instantiated twice, for re and im.
- The counter, the result register, the handshake and ovr live in the top level.

## Test plan
All scenarios use LEN = 4, IN_W = 64, ACC_W = 66.
- Basic frame: products (1,2), (3,4), (5,6), (7,8) on consecutive cycles, out_ready = 1 → one cycle later out_valid = 1, out_re = 16, out_im = 20; cnt sequence 1, 2, 3, 0.
- Width extremes: four products of (-2^63, 2^63-1) → out_re = -2^65, out_im = 2^65-4, with no wrap.
- Back-pressure: out_ready = 0 for 3 cycles after a result, while the next frame is fed → result held stable, ovr = 0. Then hold out_ready = 0 through the next completion → ovr = 1 and the first result is still on the outputs.
- clr mid-frame: two products, then clr with in_valid and (10,10), then three more (1,1) → result (13,13), ovr = 0.
- Gapped input: in_valid toggling 1010… over 8 cycles → the frame completes on the 4th valid product; idle cycles do not change acc or cnt.
- Reset mid-frame with a result pending: assert rst_n = 0 asynchronously → all outputs are 0 immediately. After release, a fresh 4-product frame gives the correct sum.
